seg_capture: RTL and testbench

SEG_CAPTURE -- requirements
Module: seg_capture

---
 rtl/seg_capture_pkg.sv | 42 ++++
 rtl/seg_to_bcd.sv | 29 ++
 rtl/seg_capture.sv | 137 +++++++++++++
 tb/tb_seg_capture.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_capture_pkg.sv
// Shared seven-segment constants: active-low segment patterns (a..g, a first)
// and the capture FSM state encoding, also used by the display decoder.
package seg_capture_pkg;

    localparam logic [0:6] SEG_0 = 7'b0000001;
    localparam logic [0:6] SEG_1 = 7'b1001111;
    localparam logic [0:6] SEG_2 = 7'b0010010;
    localparam logic [0:6] SEG_3 = 7'b0000110;
    localparam logic [0:6] SEG_4 = 7'b1001100;
    localparam logic [0:6] SEG_5 = 7'b0100100;
    localparam logic [0:6] SEG_6 = 7'b0100000;
    localparam logic [0:6] SEG_7 = 7'b0001111;
    localparam logic [0:6] SEG_8 = 7'b0000000;
    localparam logic [0:6] SEG_9 = 7'b0001100;

    localparam logic [3:0] BCD_ERR = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_HELD  = 2'd2
    } state_t;

    // A digit is only being driven when exactly one anode is pulled low.
    function automatic logic one_low(input logic [3:0] an);
        return (an == 4'b1110) || (an == 4'b1101) ||
               (an == 4'b1011) || (an == 4'b0111);
    endfunction

    function automatic logic [1:0] low_index(input logic [3:0] an);
        logic [1:0] idx;
        idx = 2'd0;
        case (an)
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/seg_to_bcd.sv
// Combinational lookup from an active-low segment pattern to its BCD value;
// unrecognised patterns give 4'hF with err set.
module seg_to_bcd
    import seg_capture_pkg::*;
(
    input  logic [0:6] seg,
    output logic [3:0] value,
    output logic       err
);

    always_comb begin
        value = BCD_ERR;
        err   = 1'b1;
        case (seg)
            SEG_0: begin value = 4'd0; err = 1'b0; end
            SEG_1: begin value = 4'd1; err = 1'b0; end
            SEG_2: begin value = 4'd2; err = 1'b0; end
            SEG_3: begin value = 4'd3; err = 1'b0; end
            SEG_4: begin value = 4'd4; err = 1'b0; end
            SEG_5: begin value = 4'd5; err = 1'b0; end
            SEG_6: begin value = 4'd6; err = 1'b0; end
            SEG_7: begin value = 4'd7; err = 1'b0; end
            SEG_8: begin value = 4'd8; err = 1'b0; end
            SEG_9: begin value = 4'd9; err = 1'b0; end
            default: begin value = BCD_ERR; err = 1'b1; end
        endcase
    end

endmodule

// File: rtl/seg_capture.sv
// Snoops a multiplexed 4-digit seven-segment bus, captures each digit once it
// has been stable long enough, and publishes a full frame of BCD digits.
module seg_capture
    import seg_capture_pkg::*;
#(
    parameter int STABLE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  an,
    input  logic [0:6]  seg,
    output logic [15:0] digits,
    output logic [3:0]  digit_err,
    output logic        frame_valid
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(STABLE_CYCLES);

    logic [3:0]    an_q;
    logic [0:6]    seg_q;
    state_t        state;
    logic [CW-1:0] cnt;
    logic [3:0]    ref_an;
    logic [0:6]    ref_seg;
    logic [3:0]    mask;
    logic [15:0]   shadow_digits;
    logic [3:0]    shadow_err;
    logic          copy_done;

    logic          sample_sel;
    logic          same_ref;
    logic [1:0]    slot;
    logic [3:0]    dec_value;
    logic          dec_err;
    logic [15:0]   cap_digits;
    logic [3:0]    cap_err;
    logic [3:0]    cap_mask;

    seg_to_bcd u_dec (
        .seg   (seg_q),
        .value (dec_value),
        .err   (dec_err)
    );

    assign sample_sel = one_low(an_q);
    assign slot       = low_index(an_q);
    assign same_ref   = (an_q == ref_an) && (seg_q == ref_seg);

    // Shadow state as it would look if the current sample were captured now,
    // so a frame-completing capture can be published on the same edge.
    always_comb begin
        cap_digits = shadow_digits;
        cap_err    = shadow_err;
        cap_mask   = mask;
        cap_digits[{slot, 2'b00} +: 4] = dec_value;
        cap_err[slot]  = dec_err;
        cap_mask[slot] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            an_q          <= 4'hF;
            seg_q         <= '1;
            state         <= ST_IDLE;
            cnt           <= '0;
            ref_an        <= '0;
            ref_seg       <= '0;
            mask          <= '0;
            shadow_digits <= '0;
            shadow_err    <= '0;
            digits        <= '0;
            digit_err     <= '0;
            copy_done     <= 1'b0;
            frame_valid   <= 1'b0;
        end else begin
            an_q        <= an;
            seg_q       <= seg;
            copy_done   <= 1'b0;
            frame_valid <= copy_done;
            case (state)
                ST_IDLE: begin
                    if (sample_sel) begin
                        state   <= ST_TRACK;
                        cnt     <= CNT_ONE;
                        ref_an  <= an_q;
                        ref_seg <= seg_q;
                    end
                end
                ST_TRACK: begin
                    if (!sample_sel) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else if (!same_ref) begin
                        cnt     <= CNT_ONE;
                        ref_an  <= an_q;
                        ref_seg <= seg_q;
                    end else if (cnt == CNT_LAST) begin
                        // Counter saturates here; HELD blocks a second capture of the same run.
                        cnt           <= CNT_FULL;
                        state         <= ST_HELD;
                        shadow_digits <= cap_digits;
                        shadow_err    <= cap_err;
                        if (cap_mask == 4'hF) begin
                            digits    <= cap_digits;
                            digit_err <= cap_err;
                            mask      <= '0;
                            copy_done <= 1'b1;
                        end else begin
                            mask <= cap_mask;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_HELD: begin
                    if (!sample_sel) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else if (!same_ref) begin
                        state   <= ST_TRACK;
                        cnt     <= CNT_ONE;
                        ref_an  <= an_q;
                        ref_seg <= seg_q;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg_capture.sv
// Bench for seg_capture: directed vector table, a latency sequence and random
// traffic, all checked every cycle against a run-length reference model.
module tb_seg_capture;

    localparam int N = 4;

    localparam logic [0:6] P0 = 7'b0000001;
    localparam logic [0:6] P1 = 7'b1001111;
    localparam logic [0:6] P2 = 7'b0010010;
    localparam logic [0:6] P3 = 7'b0000110;
    localparam logic [0:6] P4 = 7'b1001100;
    localparam logic [0:6] P5 = 7'b0100100;
    localparam logic [0:6] P6 = 7'b0100000;
    localparam logic [0:6] P7 = 7'b0001111;
    localparam logic [0:6] P8 = 7'b0000000;
    localparam logic [0:6] P9 = 7'b0001100;
    localparam logic [0:6] PX = 7'b1111111;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  an;
    logic [0:6]  seg;
    logic [15:0] digits;
    logic [3:0]  digit_err;
    logic        frame_valid;

    seg_capture #(.STABLE_CYCLES(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .an          (an),
        .seg         (seg),
        .digits      (digits),
        .digit_err   (digit_err),
        .frame_valid (frame_valid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int frames_seen = 0;

    logic [0:6] pats [10] = '{P0, P1, P2, P3, P4, P5, P6, P7, P8, P9};

    // Reference model: a digit is captured when a selected sample has been seen
    // N times in a row; four distinct slots captured make a frame.
    logic [3:0]  m_an_q;
    logic [0:6]  m_seg_q;
    logic [3:0]  m_last_an;
    logic [0:6]  m_last_seg;
    int          m_run;
    logic [3:0]  m_shadow [4];
    logic [3:0]  m_shadow_err;
    logic [3:0]  m_mask;
    logic [15:0] m_digits;
    logic [3:0]  m_err;
    logic        m_done;
    logic        m_fv;

    typedef struct {
        logic        rst;
        logic [3:0]  an;
        logic [0:6]  seg;
        int          cycles;
        logic [15:0] exp_digits;
        logic [3:0]  exp_err;
        int          exp_frames;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic [3:0] a, input logic [0:6] s,
                                input int c, input logic [15:0] d, input logic [3:0] e,
                                input int f);
        vec_t v;
        v.rst = r; v.an = a; v.seg = s; v.cycles = c;
        v.exp_digits = d; v.exp_err = e; v.exp_frames = f;
        return v;
    endfunction

    task automatic model_reset();
        m_an_q = 4'hF;
        m_seg_q = '1;
        m_last_an = '0;
        m_last_seg = '0;
        m_run = 0;
        for (int i = 0; i < 4; i++) m_shadow[i] = '0;
        m_shadow_err = '0;
        m_mask = '0;
        m_digits = '0;
        m_err = '0;
        m_done = 1'b0;
        m_fv = 1'b0;
    endtask

    task automatic model_capture();
        int slot;
        int val;
        slot = 0;
        for (int i = 0; i < 4; i++) if (!m_an_q[i]) slot = i;
        val = -1;
        for (int p = 0; p < 10; p++) if (pats[p] == m_seg_q) val = p;
        m_shadow[slot] = (val < 0) ? 4'hF : 4'(val);
        m_shadow_err[slot] = (val < 0);
        m_mask[slot] = 1'b1;
        if (m_mask == 4'hF) begin
            m_digits = {m_shadow[3], m_shadow[2], m_shadow[1], m_shadow[0]};
            m_err = m_shadow_err;
            m_mask = '0;
            m_done = 1'b1;
        end
    endtask

    task automatic model_step(input logic r, input logic [3:0] a, input logic [0:6] s);
        if (r) begin
            model_reset();
            return;
        end
        m_fv = m_done;
        m_done = 1'b0;
        if ($countones(~m_an_q) != 1) begin
            m_run = 0;
        end else if (m_run > 0 && m_an_q == m_last_an && m_seg_q == m_last_seg) begin
            m_run++;
        end else begin
            m_run = 1;
            m_last_an = m_an_q;
            m_last_seg = m_seg_q;
        end
        if (m_run == N) model_capture();
        m_an_q = a;
        m_seg_q = s;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        check("digits", digits, m_digits);
        check("digit_err", 16'(digit_err), 16'(m_err));
        check("frame_valid", 16'(frame_valid), 16'(m_fv));
    endtask

    task automatic applyStimulus(input logic r, input logic [3:0] a, input logic [0:6] s);
        reset = r;
        an = a;
        seg = s;
        @(posedge clk);
        model_step(r, a, s);
        #1;
        checkOutput();
        if (frame_valid === 1'b1) frames_seen++;
    endtask

    initial begin
        reset = 1'b1;
        an = 4'hF;
        seg = PX;
        model_reset();

        vecs.push_back(mk(1, 4'hF, PX, 2, 16'h0000, 4'h0, 0));
        vecs.push_back(mk(0, 4'b1110, P1, 8, 16'h0000, 4'h0, 0));
        vecs.push_back(mk(0, 4'b1101, P2, 8, 16'h0000, 4'h0, 0));
        vecs.push_back(mk(0, 4'b1011, P3, 8, 16'h0000, 4'h0, 0));
        vecs.push_back(mk(0, 4'b0111, P4, 8, 16'h4321, 4'h0, 1));
        vecs.push_back(mk(0, 4'b1110, P0, 3, 16'h4321, 4'h0, 1));
        vecs.push_back(mk(0, 4'b1111, P0, 4, 16'h4321, 4'h0, 1));
        vecs.push_back(mk(0, 4'b1100, P8, 20, 16'h4321, 4'h0, 1));
        vecs.push_back(mk(0, 4'b1110, PX, 10, 16'h4321, 4'h0, 1));
        vecs.push_back(mk(0, 4'b1101, P5, 8, 16'h4321, 4'h0, 1));
        vecs.push_back(mk(0, 4'b1011, P6, 8, 16'h4321, 4'h0, 1));
        vecs.push_back(mk(0, 4'b0111, P7, 8, 16'h765F, 4'h1, 2));
        vecs.push_back(mk(0, 4'b1110, P8, 8, 16'h765F, 4'h1, 2));
        vecs.push_back(mk(0, 4'b1110, P9, 8, 16'h765F, 4'h1, 2));
        vecs.push_back(mk(0, 4'b1101, P1, 8, 16'h765F, 4'h1, 2));
        vecs.push_back(mk(0, 4'b1011, P2, 8, 16'h765F, 4'h1, 2));
        vecs.push_back(mk(0, 4'b0111, P3, 8, 16'h3219, 4'h0, 3));
        vecs.push_back(mk(0, 4'b1110, P4, 8, 16'h3219, 4'h0, 3));
        vecs.push_back(mk(0, 4'b1101, P5, 8, 16'h3219, 4'h0, 3));
        vecs.push_back(mk(0, 4'b1011, P6, 8, 16'h3219, 4'h0, 3));
        vecs.push_back(mk(1, 4'hF, PX, 2, 16'h0000, 4'h0, 3));
        vecs.push_back(mk(0, 4'b0111, P7, 8, 16'h0000, 4'h0, 3));
        vecs.push_back(mk(0, 4'hF, PX, 4, 16'h0000, 4'h0, 3));

        $display("[TB] directed vector table: %0d rows", vecs.size());
        for (int v = 0; v < vecs.size(); v++) begin
            for (int c = 0; c < vecs[v].cycles; c++)
                applyStimulus(vecs[v].rst, vecs[v].an, vecs[v].seg);
            check($sformatf("row%0d_digits", v), digits, vecs[v].exp_digits);
            check($sformatf("row%0d_err", v), 16'(digit_err), 16'(vecs[v].exp_err));
            check($sformatf("row%0d_frames", v), 16'(frames_seen), 16'(vecs[v].exp_frames));
        end

        // Exact latency: last digit held for exactly N cycles, then idle.
        $display("[TB] latency sequence");
        for (int c = 0; c < 2; c++) applyStimulus(1'b1, 4'hF, PX);
        for (int c = 0; c < 40; c++) applyStimulus(1'b0, 4'b1110, P1);
        for (int c = 0; c < 6; c++) applyStimulus(1'b0, 4'b1101, P2);
        for (int c = 0; c < 6; c++) applyStimulus(1'b0, 4'b0111, P4);
        for (int c = 0; c < N; c++) applyStimulus(1'b0, 4'b1011, P3);
        check("lat_before_copy", digits, 16'h0000);
        applyStimulus(1'b0, 4'hF, PX);
        check("lat_copy_digits", digits, 16'h4321);
        check("lat_copy_fv_low", 16'(frame_valid), 16'h0);
        applyStimulus(1'b0, 4'hF, PX);
        check("lat_fv_high", 16'(frame_valid), 16'h1);
        applyStimulus(1'b0, 4'hF, PX);
        check("lat_fv_one_cycle", 16'(frame_valid), 16'h0);
        for (int c = 0; c < 5; c++) applyStimulus(1'b0, 4'hF, PX);
        check("lat_digits_hold", digits, 16'h4321);

        $display("[TB] random traffic");
        for (int k = 0; k < 300; k++) begin
            logic       r;
            logic [3:0] a;
            logic [0:6] s;
            int         sel;
            int         cyc;
            r = ($urandom_range(0, 39) == 0);
            sel = $urandom_range(0, 9);
            if (sel <= 5)      a = ~(4'b0001 << $urandom_range(0, 3));
            else if (sel == 6) a = 4'hF;
            else if (sel == 7) a = 4'b1100;
            else               a = 4'($urandom);
            if ($urandom_range(0, 9) < 8) s = pats[$urandom_range(0, 9)];
            else                          s = 7'($urandom);
            cyc = r ? 1 : $urandom_range(1, 8);
            for (int c = 0; c < cyc; c++) applyStimulus(r, a, s);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
